// File: rtl/scale_arbiter.sv
// -----------------------------------------------------------------------------
// scale_arbiter
//
// Shares one pipelined scale unit between N_REQ requesters (attention heads).
// Requesters are granted round-robin. Once a requester starts a multi-beat row,
// it keeps the grant until its last beat. Every accepted beat is forwarded to
// the scale unit one cycle later. A tag {requester index, last} is queued for
// each beat, so every scale result can be routed back to the requester that
// sent it.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   req_valid[N]     per-requester beat valid
//   req_bar[N*W]     per-requester beat data, requester i at [i*W +: W]
//   req_last[N]      last beat of the requester's row
//   req_ready[N]     per-requester beat accept (combinational, at most one hot)
//   scale_in_bar     registered beat data to the scale unit
//   scale_in_valid   registered beat valid to the scale unit
//   scale_out_bar    scale unit result
//   scale_out_valid  scale unit result valid (pops one tag)
//   rsp_valid[N]     one-hot result valid to the owning requester
//   rsp_bar          result data, shared by all requesters
//   rsp_last         result is the last beat of its row
//   busy             row lock held or beats in flight
//   err_orphan       sticky: a result arrived while no tag was queued
//
// Handshake: a beat moves on a rising edge where req_valid[i] and req_ready[i]
// are both 1. req_ready never depends on anything but req_valid and registered
// state. Results carry no backpressure; requesters must always take rsp_valid.
// -----------------------------------------------------------------------------
module scale_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_bar,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       scale_in_bar,
  output logic                    scale_in_valid,
  input  logic [DATA_W-1:0]       scale_out_bar,
  input  logic                    scale_out_valid,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_bar,
  output logic                    rsp_last,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int TAG_W = IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   rr_ptr, rr_next;

  // Tag FIFO: each entry is {requester index, last}.
  logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               tag_full;
  logic               tag_empty;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [DATA_W-1:0]  sel_bar;
  logic               sel_last;
  logic               xfer;
  logic               push;
  logic               pop;
  logic [TAG_W-1:0]   rd_tag;

  assign tag_full  = (count == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count == '0);

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  // While locked, the owner is the only candidate regardless of the search.
  assign sel_idx  = (state == LOCK) ? owner : grant_idx;
  assign sel_bar  = req_bar[int'(sel_idx)*DATA_W +: DATA_W];
  assign sel_last = req_last[sel_idx];
  assign xfer     = |(req_valid & req_ready);
  assign push     = xfer;
  assign pop      = scale_out_valid && !tag_empty;
  assign rd_tag   = tag_mem[rd_ptr];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= IDX_W'(N_REQ - 1);
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_next;
    end
  end

  // FSM next state and grant outputs.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    req_ready  = '0;

    // A full tag FIFO stalls everyone; reset holds everyone off as well.
    if (!rst && !tag_full) begin
      if (state == LOCK) begin
        req_ready[owner] = req_valid[owner];
      end else if (grant_found) begin
        req_ready[grant_idx] = 1'b1;
      end
    end

    if (xfer) begin
      case (state)
        IDLE: begin
          if (sel_last) begin
            rr_next = sel_idx;
          end else begin
            state_next = LOCK;
            owner_next = sel_idx;
          end
        end
        LOCK: begin
          if (sel_last) begin
            state_next = IDLE;
            rr_next    = owner;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Tag storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= {sel_idx, sel_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered datapath toward the scale unit and back to the requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      scale_in_valid <= 1'b0;
      scale_in_bar   <= '0;
      rsp_valid      <= '0;
      rsp_bar        <= '0;
      rsp_last       <= 1'b0;
      err_orphan     <= 1'b0;
    end else begin
      scale_in_valid <= xfer;
      if (xfer) begin
        scale_in_bar <= sel_bar;
      end
      if (pop) begin
        rsp_valid <= N_REQ'(1) << rd_tag[TAG_W-1:1];
        rsp_bar   <= scale_out_bar;
        rsp_last  <= rd_tag[0];
      end else begin
        rsp_valid <= '0;
        rsp_last  <= 1'b0;
      end
      if (scale_out_valid && tag_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign busy = (state == LOCK) || !tag_empty;

endmodule

// File: tb/tb_scale_arbiter.sv
// -----------------------------------------------------------------------------
// tb_scale_arbiter
//
// Directed scenarios (single beat, fairness, row lock, full FIFO, orphan
// result, reset mid-row) followed by a randomized run. A behavioural model
// tracks the round-robin pointer, row lock and tag queue and predicts every
// DUT output each cycle. The bench plays the role of the scale unit.
// -----------------------------------------------------------------------------
module tb_scale_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bar;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   scale_in_bar;
  logic           scale_in_valid;
  logic [W-1:0]   scale_out_bar;
  logic           scale_out_valid;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_bar;
  logic           rsp_last;
  logic           busy;
  logic           err_orphan;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit             m_lock;
  int             m_owner;
  int             m_rr;
  logic [2:0]     m_tags[$];      // {requester index, last}
  logic           e_siv;
  logic [W-1:0]   e_sib;
  logic [N-1:0]   e_rv;
  logic [W-1:0]   e_rb;
  logic           e_rl;
  logic           e_orph;

  scale_arbiter #(.N_REQ(N), .DATA_W(W), .TAG_DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_bar         (req_bar),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .scale_in_bar    (scale_in_bar),
    .scale_in_valid  (scale_in_valid),
    .scale_out_bar   (scale_out_bar),
    .scale_out_valid (scale_out_valid),
    .rsp_valid       (rsp_valid),
    .rsp_bar         (rsp_bar),
    .rsp_last        (rsp_last),
    .busy            (busy),
    .err_orphan      (err_orphan)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Grant the model expects for the current inputs.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst || m_tags.size() >= D) return r;
    if (m_lock) begin
      r[m_owner] = req_valid[m_owner];
      return r;
    end
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_rr + k) % N]) begin
        r[(m_rr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_lock  = 1'b0;
    m_owner = 0;
    m_rr    = N - 1;
    m_tags.delete();
    e_siv   = 1'b0;
    e_sib   = '0;
    e_rv    = '0;
    e_rb    = '0;
    e_rl    = 1'b0;
    e_orph  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs in force.
  task automatic model_update();
    logic [N-1:0] g;
    logic [2:0]   t;
    int           idx;
    logic         last;
    if (rst) begin
      model_reset();
      return;
    end
    g = model_ready() & req_valid;
    e_rv = '0;
    e_rl = 1'b0;
    if (scale_out_valid) begin
      if (m_tags.size() > 0) begin
        t    = m_tags.pop_front();
        e_rv = N'(1) << t[2:1];
        e_rb = scale_out_bar;
        e_rl = t[0];
      end else begin
        e_orph = 1'b1;
      end
    end
    if (g != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (g[i]) idx = i;
      last = req_last[idx];
      m_tags.push_back({2'(idx), last});
      e_siv = 1'b1;
      e_sib = req_bar[idx*W +: W];
      if (m_lock) begin
        if (last) begin
          m_lock = 1'b0;
          m_rr   = idx;
        end
      end else if (last) begin
        m_rr = idx;
      end else begin
        m_lock  = 1'b1;
        m_owner = idx;
      end
    end else begin
      e_siv = 1'b0;
    end
  endtask

  // One cycle: compare everything at the falling edge, then step the model.
  task automatic tick();
    @(negedge clk);
    chk("req_ready", W'(req_ready), W'(model_ready()));
    chk("scale_in_valid", W'(scale_in_valid), W'(e_siv));
    chk("scale_in_bar", scale_in_bar, e_sib);
    chk("rsp_valid", W'(rsp_valid), W'(e_rv));
    if (e_rv != '0) begin
      chk("rsp_bar", rsp_bar, e_rb);
      chk("rsp_last", W'(rsp_last), W'(e_rl));
    end
    chk("busy", W'(busy), W'(m_lock || m_tags.size() != 0));
    chk("err_orphan", W'(err_orphan), W'(e_orph));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req_valid       = '0;
    req_last        = '0;
    scale_out_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    req_valid       = '0;
    req_bar         = '0;
    req_last        = '0;
    scale_out_bar   = '0;
    scale_out_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));

    // Single beat from requester 0.
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    req_bar[0 +: W] = 64'h00fc00fd00fe00ff;
    #1;
    chk("single_ready", W'(req_ready), W'(4'b0001));
    tick();
    req_valid = '0;
    chk("single_siv", W'(scale_in_valid), W'(1));
    chk("single_sib", scale_in_bar, 64'h00fc00fd00fe00ff);
    tick();
    chk("single_siv_low", W'(scale_in_valid), W'(0));
    scale_out_valid = 1'b1;
    scale_out_bar   = 64'h0123456789abcdef;
    tick();
    scale_out_valid = 1'b0;
    chk("single_rsp_valid", W'(rsp_valid), W'(4'b0001));
    chk("single_rsp_last", W'(rsp_last), W'(1));
    chk("single_rsp_bar", rsp_bar, 64'h0123456789abcdef);
    tick();

    // Fairness: everyone always valid with single-beat rows.
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) req_bar[i*W +: W] = {$urandom, $urandom};
      #1;
      chk("fair_grant", W'(req_ready), W'(4'b0001 << (k % 4)));
      tick();
    end
    req_valid = '0;

    // Row lock: requester 2 sends a 4-beat row while the others wait.
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    #1;
    chk("lock_first", W'(req_ready), W'(4'b0100));
    tick();
    req_valid = 4'b1111;
    req_last  = 4'b1011;
    for (int beat = 2; beat <= 4; beat++) begin
      req_last[2] = (beat == 4);
      req_bar[2*W +: W] = {$urandom, $urandom};
      #1;
      chk("lock_beat", W'(req_ready), W'(4'b0100));
      tick();
    end
    #1;
    chk("lock_next", W'(req_ready), W'(4'b1000));
    tick();
    req_valid = '0;

    // Full: scale unit silent, requester 1 always valid.
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    for (int k = 0; k < D; k++) begin
      req_bar[1*W +: W] = {$urandom, $urandom};
      #1;
      chk("full_fill", W'(req_ready), W'(4'b0010));
      tick();
    end
    #1;
    chk("full_stall", W'(req_ready), W'(0));
    tick();
    chk("full_stall2", W'(req_ready), W'(0));
    scale_out_valid = 1'b1;
    scale_out_bar   = {$urandom, $urandom};
    tick();
    scale_out_valid = 1'b0;
    chk("full_pop_rsp", W'(rsp_valid), W'(4'b0010));
    chk("full_one_more", W'(req_ready), W'(4'b0010));
    tick();
    chk("full_again", W'(req_ready), W'(0));
    tick();

    // Orphan result.
    do_reset();
    scale_out_valid = 1'b1;
    scale_out_bar   = {$urandom, $urandom};
    tick();
    scale_out_valid = 1'b0;
    chk("orphan_set", W'(err_orphan), W'(1));
    chk("orphan_no_rsp", W'(rsp_valid), W'(0));
    for (int k = 0; k < 3; k++) tick();
    chk("orphan_sticky", W'(err_orphan), W'(1));
    do_reset();
    chk("orphan_cleared", W'(err_orphan), W'(0));

    // Reset mid-row with 3 beats in flight.
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      req_bar[0 +: W] = {$urandom, $urandom};
      #1;
      chk("midrow_owner", W'(req_ready), W'(4'b0001));
      tick();
    end
    chk("midrow_busy", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    chk("midrow_rst_ready", W'(req_ready), W'(0));
    tick();
    chk("midrow_busy_cleared", W'(busy), W'(0));
    chk("midrow_ready_low", W'(req_ready), W'(0));
    rst = 1'b0;
    #1;
    chk("midrow_first_grant", W'(req_ready), W'(4'b0001));
    tick();
    do_reset();

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 800; c++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_last[i]       = ($urandom_range(0, 2) == 0);
        req_bar[i*W +: W] = {$urandom, $urandom};
      end
      scale_out_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
      scale_out_bar   = {$urandom, $urandom};
      tick();
    end
    req_valid       = '0;
    scale_out_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scale_arbiter.md
SCALE_ARBITER -- requirements
Module: scale_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- N_REQ, 4, number of requesters (attention heads) sharing one scale unit
- DATA_W, 64, bar width (4 x 16-bit lanes)
- TAG_DEPTH, 8, maximum beats in flight inside the scale unit
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous active-high reset
- req_valid, in, N_REQ, per-requester beat valid
- req_bar, in, N_REQ*DATA_W, per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last, in, N_REQ, last beat of requester's row
- req_ready, out, N_REQ, per-requester beat accept
- scale_in_bar, out, DATA_W, data to scale unit
- scale_in_valid, out, 1, maps to scale bar_valid
- scale_out_bar, in, DATA_W, scale unit result
- scale_out_valid, in, 1, scale unit result valid
- rsp_valid, out, N_REQ, one-hot result valid to the owning requester
- rsp_bar, out, DATA_W, result data, shared by all requesters
- rsp_last, out, 1, result is the last beat of its row
- busy, out, 1, arbiter locked or beats in flight
- err_orphan, out, 1, sticky flag: result arrived with no tag
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 A transfer SHALL occur on a clock edge where req_valid[i] and req_ready[i] are both 1.
REQ-005 req_ready SHALL be combinational, at most one bit high per cycle, and all zero whenever the tag count equals TAG_DEPTH.
REQ-006 The FSM SHALL have two states, IDLE and LOCK.
REQ-007 In IDLE, req_ready SHALL go to the first requester with req_valid=1, searching round-robin from rr_ptr+1 modulo N_REQ.
REQ-008 From IDLE, a transfer with req_last=0 SHALL move the FSM to LOCK with owner equal to the granted requester.
REQ-009 From IDLE, a transfer with req_last=1 SHALL keep the FSM in IDLE and set rr_ptr to the granted requester.
REQ-010 In LOCK, only req_ready[owner] SHALL be able to assert; other requesters SHALL be starved until the row ends.
REQ-011 In LOCK, a transfer with req_last=1 SHALL return the FSM to IDLE and set rr_ptr to owner.
REQ-012 On each transfer, scale_in_valid SHALL be 1 and scale_in_bar SHALL equal the granted req_bar on the next cycle (1-cycle registered latency).
REQ-013 scale_in_valid SHALL be 0 in cycles following no transfer; scale_in_bar SHALL hold its last value.
REQ-014 On each transfer, a tag {requester index, req_last} SHALL be pushed into a TAG_DEPTH-entry FIFO.
REQ-015 Each scale_out_valid SHALL pop exactly one tag.
REQ-016 A simultaneous push and pop SHALL leave the tag count unchanged.
REQ-017 The tag count SHALL never exceed TAG_DEPTH, and the FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-018 One cycle after scale_out_valid with a non-empty FIFO, the arbiter SHALL drive:
- rsp_valid = one-hot(tag index)
- rsp_bar = scale_out_bar
- rsp_last = tag last
REQ-019 rsp_valid SHALL be zero in every other cycle. Requesters SHALL always accept responses; there is no response backpressure.
REQ-020 scale_out_valid with the FIFO empty SHALL set err_orphan, produce no rsp_valid and pop nothing.
REQ-021 err_orphan SHALL stay set until reset.
REQ-022 busy SHALL be 1 when state is LOCK or tag count is nonzero, and 0 otherwise.

Reset
REQ-023 While rst=1 at an edge, the arbiter SHALL enter IDLE, set rr_ptr to N_REQ-1 (requester 0 has first priority) and empty the FIFO.
REQ-024 While rst=1 at an edge, the arbiter SHALL drive all outputs to 0, including scale_in_bar, rsp_bar and err_orphan.
REQ-025 req_ready SHALL be 0 during the reset cycle.
REQ-026 Reset mid-row or with beats in flight SHALL discard the lock and all tags.
REQ-027 The scale unit SHALL be reset in the same cycle as the arbiter.

Verification
REQ-028 Single beat: req 0 sends bar 64'h00fc00fd00fe00ff with last=1 -> next cycle scale_in_valid=1 with that data; a scale result gives rsp_valid=4'b0001 and rsp_last=1 one cycle later.
REQ-029 Fairness: all 4 requesters hold single-beat rows (last=1) continuously -> grant order 0,1,2,3,0,1,... with no requester skipped.
REQ-030 Row lock: req 2 sends a 4-beat row while reqs 0, 1 and 3 are valid -> 4 consecutive grants to req 2 with no interleave; the next grant goes to req 3.
REQ-031 Full: scale unit held silent, one requester always valid -> exactly 8 transfers, then req_ready=0; one scale_out_valid -> one further transfer allowed.
REQ-032 Orphan: scale_out_valid pulsed with the FIFO empty -> err_orphan=1 and stays 1, rsp_valid stays 0; a subsequent rst clears it.
REQ-033 Reset mid-row: rst asserted in LOCK with 3 tags in flight -> next cycle busy=0, req_ready=0; after release, req 0 (valid) is granted first.
